// File: rtl/mem_unit.sv
// Memory-stage unit: passes ALU results straight to writeback, or runs one
// LW/SW handshake with data memory, guarded by a 4-bit timeout counter.
module mem_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_to_mem_in,
    input  logic        ret_future_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        ret_wb,
    output logic        mem_err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [15:0] addr_r, addr_s;
    logic [15:0] wdata_r, wdata_s;
    logic [3:0]  rd_r, rd_s;
    logic        ret_r, ret_s;
    logic        we_r, we_s;
    logic        wb_valid_r, wb_valid_s;
    logic [15:0] wb_data_r, wb_data_s;
    logic [3:0]  wb_rd_r, wb_rd_s;
    logic        wb_reg_write_r, wb_reg_write_s;
    logic        ret_wb_r, ret_wb_s;
    logic        mem_err_r, mem_err_s;
    logic        is_mem_s;

    assign is_mem_s = mem_to_reg_in | reg_to_mem_in;

    // Next-state and next-output logic; a store flag wins over a load flag.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        addr_s         = addr_r;
        wdata_s        = wdata_r;
        rd_s           = rd_r;
        ret_s          = ret_r;
        we_s           = we_r;
        wb_valid_s     = 1'b0;
        wb_data_s      = wb_data_r;
        wb_rd_s        = wb_rd_r;
        wb_reg_write_s = 1'b0;
        ret_wb_s       = 1'b0;
        mem_err_s      = mem_err_r;
        case (state_r)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem_s) begin
                        state_s = ACCESS;
                        cnt_s   = 4'd0;
                        addr_s  = alu_result;
                        wdata_s = store_data;
                        rd_s    = reg_rd_in;
                        ret_s   = ret_future_in;
                        we_s    = reg_to_mem_in;
                    end else begin
                        wb_valid_s     = 1'b1;
                        wb_data_s      = alu_result;
                        wb_rd_s        = reg_rd_in;
                        wb_reg_write_s = 1'b1;
                        ret_wb_s       = ret_future_in;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_s    = IDLE;
                    wb_valid_s = 1'b1;
                    wb_rd_s    = rd_r;
                    ret_wb_s   = ret_r;
                    if (we_r) begin
                        wb_data_s      = addr_r;
                        wb_reg_write_s = 1'b0;
                    end else begin
                        wb_data_s      = mem_rdata;
                        wb_reg_write_s = 1'b1;
                    end
                end else if (cnt_r == 4'd15) begin
                    // Timeout: report a poisoned, non-writing result.
                    state_s    = IDLE;
                    mem_err_s  = 1'b1;
                    wb_valid_s = 1'b1;
                    wb_data_s  = 16'hFFFF;
                end else begin
                    cnt_s = cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= 4'd0;
            addr_r         <= 16'd0;
            wdata_r        <= 16'd0;
            rd_r           <= 4'd0;
            ret_r          <= 1'b0;
            we_r           <= 1'b0;
            wb_valid_r     <= 1'b0;
            wb_data_r      <= 16'd0;
            wb_rd_r        <= 4'd0;
            wb_reg_write_r <= 1'b0;
            ret_wb_r       <= 1'b0;
            mem_err_r      <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            addr_r         <= addr_s;
            wdata_r        <= wdata_s;
            rd_r           <= rd_s;
            ret_r          <= ret_s;
            we_r           <= we_s;
            wb_valid_r     <= wb_valid_s;
            wb_data_r      <= wb_data_s;
            wb_rd_r        <= wb_rd_s;
            wb_reg_write_r <= wb_reg_write_s;
            ret_wb_r       <= ret_wb_s;
            mem_err_r      <= mem_err_s;
        end
    end

    assign mem_req      = (state_r == ACCESS);
    assign mem_we       = we_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = wdata_r;
    assign stall        = (state_r == ACCESS) | (valid_in & is_mem_s);
    assign wb_valid     = wb_valid_r;
    assign wb_data      = wb_data_r;
    assign wb_rd        = wb_rd_r;
    assign wb_reg_write = wb_reg_write_r;
    assign ret_wb       = ret_wb_r;
    assign mem_err      = mem_err_r;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed scenarios followed by random
// transactions checked against a transaction-level expectation model.
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        rst, valid_in, mem_to_reg_in, reg_to_mem_in, ret_future_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result, store_data, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, wb_valid, wb_reg_write, ret_wb, mem_err;
    logic [15:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  wb_rd;

    int n_assert = 0;
    int n_fail   = 0;

    // Expectation model state
    logic        exp_err;
    logic [15:0] last_data;
    logic [3:0]  last_rd;

    mem_unit dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_to_mem_in(reg_to_mem_in), .ret_future_in(ret_future_in),
        .reg_rd_in(reg_rd_in), .alu_result(alu_result), .store_data(store_data),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .stall(stall), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ret_wb(ret_wb),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs();
        valid_in      = 1'($urandom);
        mem_to_reg_in = 1'($urandom);
        reg_to_mem_in = 1'($urandom);
        ret_future_in = 1'($urandom);
        reg_rd_in     = 4'($urandom);
        alu_result    = 16'($urandom);
        store_data    = 16'($urandom);
    endtask

    // One idle cycle; stray acks must not matter.
    task automatic do_idle();
        junk_inputs();
        valid_in  = 1'b0;
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        #1 chk("idle_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("idle_ret", 32'(ret_wb), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_hold_data", 32'(wb_data), 32'(last_data));
        chk("idle_hold_rd", 32'(wb_rd), 32'(last_rd));
        chk("idle_err", 32'(mem_err), 32'(exp_err));
    endtask

    task automatic do_alu(input logic [3:0] rd, input logic [15:0] val, input logic ret);
        junk_inputs();
        valid_in = 1'b1; mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0;
        ret_future_in = ret; reg_rd_in = rd; alu_result = val;
        mem_ack = 1'($urandom);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        @(negedge clk);
        last_data = val; last_rd = rd;
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_data", 32'(wb_data), 32'(val));
        chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
        chk("alu_wb_rw", 32'(wb_reg_write), 32'd1);
        chk("alu_ret", 32'(ret_wb), 32'(ret));
        chk("alu_req", 32'(mem_req), 32'd0);
        chk("alu_err", 32'(mem_err), 32'(exp_err));
    endtask

    // Memory op; ack arrives on access cycle number 'delay' (0-based), none if >15.
    task automatic do_mem(input logic store, input logic both, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [3:0] rd, input logic ret,
                          input int delay, input logic [15:0] rdata);
        logic acked = 1'b0;
        junk_inputs();
        valid_in = 1'b1;
        mem_to_reg_in = store ? both : 1'b1;
        reg_to_mem_in = store;
        ret_future_in = ret; reg_rd_in = rd; alu_result = addr; store_data = wd;
        mem_ack = 1'b0;
        #1 chk("mem_issue_stall", 32'(stall), 32'd1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("acc_req", 32'(mem_req), 32'd1);
            chk("acc_addr", 32'(mem_addr), 32'(addr));
            chk("acc_we", 32'(mem_we), 32'(store));
            if (store) chk("acc_wdata", 32'(mem_wdata), 32'(wd));
            chk("acc_wb_valid", 32'(wb_valid), 32'd0);
            junk_inputs();
            mem_ack   = (k == delay);
            mem_rdata = (k == delay) ? rdata : 16'($urandom);
            #1 chk("acc_stall", 32'(stall), 32'd1);
            if (k == delay) begin
                acked = 1'b1;
                break;
            end
        end
        @(negedge clk);
        chk("mem_wb_valid", 32'(wb_valid), 32'd1);
        chk("mem_req_drop", 32'(mem_req), 32'd0);
        if (acked) begin
            last_data = store ? addr : rdata;
            last_rd   = rd;
            chk("mem_wb_data", 32'(wb_data), 32'(last_data));
            chk("mem_wb_rd", 32'(wb_rd), 32'(rd));
            chk("mem_wb_rw", 32'(wb_reg_write), 32'(!store));
            chk("mem_ret", 32'(ret_wb), 32'(ret));
        end else begin
            exp_err   = 1'b1;
            last_data = 16'hFFFF;
            last_rd   = wb_rd;
            chk("to_wb_data", 32'(wb_data), 32'h0000FFFF);
            chk("to_wb_rw", 32'(wb_reg_write), 32'd0);
        end
        chk("mem_err", 32'(mem_err), 32'(exp_err));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        junk_inputs();
        mem_ack = 1'($urandom);
        @(negedge clk);
        exp_err = 1'b0; last_data = 16'd0; last_rd = 4'd0;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write), 32'd0);
        chk("rst_ret", 32'(ret_wb), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0;
        ret_future_in = 1'b0; reg_rd_in = 4'd0; alu_result = 16'd0; store_data = 16'd0;
        mem_rdata = 16'd0; mem_ack = 1'b0;
        exp_err = 1'b0; last_data = 16'd0; last_rd = 4'd0;
        @(negedge clk);
        do_reset();

        do_alu(4'd3, 16'h1234, 1'b0);
        do_mem(1'b0, 1'b0, 16'h0040, 16'h0000, 4'd5, 1'b0, 2, 16'hBEEF);
        do_mem(1'b1, 1'b0, 16'h0010, 16'h00AA, 4'd6, 1'b1, 0, 16'h0000);
        do_mem(1'b1, 1'b1, 16'h0020, 16'h0055, 4'd7, 1'b0, 1, 16'h1111);
        do_idle();
        do_alu(4'd9, 16'hCAFE, 1'b1);

        // Reset on the second access cycle discards the load.
        valid_in = 1'b1; mem_to_reg_in = 1'b1; reg_to_mem_in = 1'b0;
        alu_result = 16'h0080; reg_rd_in = 4'd2; mem_ack = 1'b0;
        @(negedge clk);
        chk("rmid_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        chk("rmid_req2", 32'(mem_req), 32'd1);
        rst = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_err = 1'b0; last_data = 16'd0; last_rd = 4'd0;
        chk("rmid_req_drop", 32'(mem_req), 32'd0);
        chk("rmid_wb_valid", 32'(wb_valid), 32'd0);
        do_idle();
        do_alu(4'd4, 16'h4321, 1'b0);

        // Timeout, then sticky error through later traffic until reset.
        do_mem(1'b0, 1'b0, 16'h0100, 16'h0000, 4'd1, 1'b0, 99, 16'h0000);
        do_idle();
        do_alu(4'd8, 16'h0808, 1'b1);
        do_reset();

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0: do_alu(4'($urandom), 16'($urandom), 1'($urandom));
                1: do_mem(1'b0, 1'b0, 16'($urandom), 16'($urandom), 4'($urandom),
                          1'($urandom), int'($urandom_range(0, 17)), 16'($urandom));
                2: do_mem(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                          1'($urandom), int'($urandom_range(0, 17)), 16'($urandom));
                default: do_idle();
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
